snake_dir_input: RTL and testbench

- Converts the three raw direction push-buttons into a queue of validated direction commands for the snake game core.
- Path: raw buttons → synchronise → debounce → decode each new button pattern into a 2-bit direction code → discard reversals and repeats → hold up to FIFO_DEPTH commands.
- The core pops one command per move tick through a valid/ready handshake.
- Sits between the board pushbuttons and the snake movement logic, replacing level sampling of the buttons on the slow move clock.

---
 rtl/snake_pkg.sv | 32 +++
 rtl/snake_debounce.sv | 44 ++++
 rtl/snake_dir_input.sv | 105 ++++++++++
 tb/tb_snake_dir_input.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared direction types and helpers for the snake game blocks.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_RIGHT = 2'b00;
  localparam dir_t DIR_UP    = 2'b01;
  localparam dir_t DIR_LEFT  = 2'b10;
  localparam dir_t DIR_DOWN  = 2'b11;
  localparam dir_t DIR_RESET = DIR_DOWN;

  // Decoded button event waiting for the filter stage.
  typedef struct packed {
    logic vld;
    dir_t code;
  } dir_cmd_t;

  function automatic dir_t dir_reverse(input dir_t d);
    return d ^ 2'b10;
  endfunction

  // Buttons are active-low; b[2] has priority over the low pair.
  function automatic dir_t dir_decode(input logic [2:0] b);
    dir_t d;
    if (!b[2])               d = DIR_LEFT;
    else if (b[1:0] == 2'b01) d = DIR_DOWN;
    else if (b[1:0] == 2'b10) d = DIR_UP;
    else                      d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/snake_debounce.sv
// One-bit 2-flop synchroniser followed by a stable-count debouncer.
module snake_debounce
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Any cycle where the synchronised bit agrees with the output restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= 1'b1;
      cnt <= '0;
    end else if (s2 == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      deb <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snake_dir_input.sv
// Pushbuttons -> debounced events -> reversal/repeat filter -> small command queue.
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] button,
  output logic [1:0] dir_code,
  output logic       dir_valid,
  input  logic       dir_ready,
  output logic [1:0] cur_dir,
  output logic       drop,
  output logic [7:0] reject_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  logic [2:0] deb, prev;
  dir_cmd_t   ev;

  for (genvar i = 0; i < 3; i++) begin : g_deb
    snake_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (button[i]),
      .deb   (deb[i])
    );
  end

  // Event stage: a new non-idle pattern is decoded and registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 3'b111;
      ev   <= '0;
    end else begin
      prev    <= deb;
      ev.vld  <= (deb != prev) && (deb != 3'b111);
      ev.code <= dir_decode(deb);
    end
  end

  dir_t        mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
  logic [PW:0]   count, count_popped;
  logic          accept, reject, full, pop, push, drop_n;

  always_comb begin
    accept       = ev.vld && (ev.code != cur_dir) && (ev.code != dir_reverse(cur_dir));
    reject       = ev.vld && (ev.code == dir_reverse(cur_dir));
    full         = (count == FULL_CNT);
    pop          = dir_valid && dir_ready;
    push         = accept && (!full || pop);
    drop_n       = accept && full && !pop;
    rd_ptr_n     = rd_ptr + PW'(pop);
    count_popped = count - (PW + 1)'(pop);
  end

  assign dir_valid = (count != '0);

  // cur_dir follows every accepted code, even one that is dropped on a full queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_dir    <= DIR_RESET;
      reject_cnt <= '0;
      drop       <= 1'b0;
    end else begin
      drop <= drop_n;
      if (accept) cur_dir <= ev.code;
      if (reject && reject_cnt != 8'hff) reject_cnt <= reject_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= DIR_RIGHT;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ev.code;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_n;
      count  <= count_popped + (PW + 1)'(push);
    end
  end

  // Head register: if the queue drains to nothing before this push, the
  // pushed code becomes the head directly; otherwise read the new head slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_code <= DIR_RIGHT;
    end else if (count_popped == '0) begin
      if (push) dir_code <= ev.code;
    end else begin
      dir_code <= mem[rd_ptr_n];
    end
  end

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed bench for snake_dir_input with DEBOUNCE_CYCLES=4, FIFO_DEPTH=2.
module tb_snake_dir_input;

  localparam int DC = 4;
  localparam int FD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] button = 3'b111;
  logic       dir_ready = 1'b0;
  logic [1:0] dir_code, cur_dir;
  logic       dir_valid, drop;
  logic [7:0] reject_cnt;

  snake_dir_input #(.DEBOUNCE_CYCLES(DC), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (button),
    .dir_code   (dir_code),
    .dir_valid  (dir_valid),
    .dir_ready  (dir_ready),
    .cur_dir    (cur_dir),
    .drop       (drop),
    .reject_cnt (reject_cnt)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int drops = 0, valids = 0;
  logic [1:0] pops [$];

  // Inputs change 1 time unit after posedge, so negedge sees the handshake the next edge uses.
  always @(negedge clk) begin
    if (drop) drops++;
    if (dir_valid) valids++;
    if (dir_valid && dir_ready) pops.push_back(dir_code);
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] b, input int n);
    button = b;
    tick(n);
  endtask

  int d0;

  initial begin
    tick(3);
    rst_n = 1'b1;
    chk("rst_valid", dir_valid, 0);
    chk("rst_code", dir_code, 0);
    chk("rst_cur", cur_dir, 3);
    chk("rst_rej", reject_cnt, 0);
    chk("rst_drop", drop, 0);

    tick(50);
    chk("idle_valids", valids, 0);
    chk("idle_cur", cur_dir, 3);
    chk("idle_rej", reject_cnt, 0);
    chk("idle_drops", drops, 0);

    // Bounce: 3-cycle presses never survive a 4-cycle debounce.
    repeat (4) begin
      press(3'b101, 3);
      press(3'b111, 2);
    end
    tick(10);
    chk("bounce_valids", valids, 0);
    // Steady press decodes to DOWN, a repeat of the reset direction.
    press(3'b101, 20);
    chk("repeat_valids", valids, 0);
    chk("repeat_cur", cur_dir, 3);
    chk("repeat_rej", reject_cnt, 0);
    chk("repeat_pops", pops.size(), 0);
    press(3'b111, 12);

    // Single LEFT command with exact latency, consumed immediately.
    dir_ready = 1'b1;
    button = 3'b011;
    tick(7);
    chk("lat_valid_e7", dir_valid, 0);
    tick(1);
    chk("lat_valid_e8", dir_valid, 1);
    chk("lat_code_e8", dir_code, 2);
    tick(1);
    chk("lat_valid_e9", dir_valid, 0);
    tick(11);
    chk("left_pops", pops.size(), 1);
    if (pops.size() > 0) chk("left_pop0", pops[0], 2);
    chk("left_cur", cur_dir, 2);
    press(3'b111, 20);
    chk("release_pops", pops.size(), 1);
    chk("release_valids", valids, 1);
    pops.delete();

    // Fill the queue with UP, LEFT; DOWN then drops but still updates cur_dir.
    dir_ready = 1'b0;
    press(3'b110, 12);
    chk("q_cur_up", cur_dir, 1);
    chk("q_valid1", dir_valid, 1);
    chk("q_head_up", dir_code, 1);
    press(3'b111, 12);
    press(3'b011, 12);
    chk("q_cur_left", cur_dir, 2);
    chk("q_nodrop", drops, 0);
    press(3'b111, 12);
    d0 = drops;
    press(3'b101, 12);
    chk("q_drop", drops - d0, 1);
    chk("q_cur_down", cur_dir, 3);
    chk("q_head_keep", dir_code, 1);
    dir_ready = 1'b1;
    tick(4);
    dir_ready = 1'b0;
    chk("q_pops", pops.size(), 2);
    if (pops.size() > 1) begin
      chk("q_pop0", pops[0], 1);
      chk("q_pop1", pops[1], 2);
    end
    chk("q_empty", dir_valid, 0);
    press(3'b111, 12);
    pops.delete();

    // Reach cur_dir=UP (queue now holds LEFT, UP), then hammer the DOWN reversal.
    press(3'b011, 12);
    press(3'b111, 12);
    press(3'b110, 12);
    chk("rv_cur_up", cur_dir, 1);
    press(3'b111, 12);
    d0 = drops;
    for (int i = 0; i < 300; i++) begin
      press(3'b101, 10);
      press(3'b111, 10);
      if (i == 0) chk("rv_rej1", reject_cnt, 1);
    end
    chk("rv_rej_sat", reject_cnt, 255);
    chk("rv_cur", cur_dir, 1);
    chk("rv_nodrop", drops - d0, 0);
    chk("rv_head", dir_code, 2);
    chk("rv_valid", dir_valid, 1);

    // Reset mid-pop with two entries queued clears everything at once.
    dir_ready = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", dir_valid, 0);
    chk("ar_cur", cur_dir, 3);
    chk("ar_rej", reject_cnt, 0);
    chk("ar_code", dir_code, 0);
    tick(2);
    rst_n = 1'b1;
    tick(20);
    chk("ar_after_valid", dir_valid, 0);
    chk("ar_after_pops", pops.size(), 0);
    chk("ar_after_rej", reject_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
